// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
//   state_e       : controller FSM encoding (idle, bit-serial run, done)
//   OP_ADD/OP_SUB : values of the op select input
//   DEFAULT_WIDTH : default operand/result width
package serial_alu_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/addsub_bit_cell.sv
// One-bit combinational add/subtract cell.
//   a_bit, b_bit : operand bits
//   cin          : incoming carry (add) or borrow (sub)
//   op           : OP_ADD = full adder, OP_SUB = full subtractor (a - b - cin)
//   s            : sum / difference bit
//   cout         : outgoing carry / borrow
module addsub_bit_cell
   import serial_alu_pkg::*;
(
   input  logic a_bit,
   input  logic b_bit,
   input  logic cin,
   input  logic op,
   output logic s,
   output logic cout
);

   logic w_axb;

   always_comb begin
      w_axb = a_bit ^ b_bit;
      s     = w_axb ^ cin;
      if (op == OP_ADD) begin
         cout = (a_bit & b_bit) | (cin & w_axb);
      end else begin
         // Borrow when b exceeds a, or bits equal and a borrow ripples through.
         cout = (~a_bit & b_bit) | (~w_axb & cin);
      end
   end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller. Accepts an operation when idle, pushes
// the operands LSB first through a single one-bit cell over WIDTH cycles, then
// publishes result, carry/borrow and (for subtract) magnitude flags with a
// one-cycle done pulse.
//   clk, rst                      : clock, synchronous active-high reset
//   start, op, a, b               : request, op select (0 add / 1 sub), operands
//   busy, done                    : operation in progress, result-valid pulse
//   result, carry_out             : sum/difference, final carry/borrow
//   a_greater, a_equal, a_less    : magnitude flags (subtract only)
module serial_addsub_ctrl
   import serial_alu_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             a_greater,
   output logic             a_equal,
   output logic             a_less
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   state_e           r_state;
   state_e           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_op;
   logic             r_carry;
   logic [CntW-1:0]  r_cnt;
   logic [WIDTH-1:0] r_result;
   logic             r_carry_out;
   logic             r_done;
   logic             r_gt;
   logic             r_eq;
   logic             r_lt;

   logic w_accept;
   logic w_last;
   logic w_s;
   logic w_cout;

   // Operand registers shift right, so bit 0 is always the bit being processed.
   addsub_bit_cell u_cell (
      .a_bit (r_a[0]),
      .b_bit (r_b[0]),
      .cin   (r_carry),
      .op    (r_op),
      .s     (w_s),
      .cout  (w_cout)
   );

   // The done pulse is registered on leaving StDone, so busy covers that cycle
   // too; a new start is only taken once the pulse has gone.
   always_comb begin
      w_state_next = r_state;
      w_accept     = (r_state == StIdle) & ~r_done & start;
      w_last       = (r_cnt == CntLast);
      case (r_state)
         StIdle:  if (w_accept) w_state_next = StRun;
         StRun:   if (w_last) w_state_next = StDone;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StIdle;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= OP_ADD;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_carry_out <= 1'b0;
         r_done      <= 1'b0;
         r_gt        <= 1'b0;
         r_eq        <= 1'b0;
         r_lt        <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_done  <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_a         <= a;
                  r_b         <= b;
                  r_op        <= op;
                  r_carry     <= 1'b0;
                  r_cnt       <= '0;
                  r_result    <= '0;
                  r_carry_out <= 1'b0;
                  r_gt        <= 1'b0;
                  r_eq        <= 1'b0;
                  r_lt        <= 1'b0;
               end
            end
            StRun: begin
               r_a      <= r_a >> 1;
               r_b      <= r_b >> 1;
               r_result <= {w_s, r_result[WIDTH-1:1]};
               r_carry  <= w_cout;
               if (w_last) begin
                  r_cnt       <= '0;
                  r_carry_out <= w_cout;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            StDone: begin
               r_done <= 1'b1;
               if (r_op == OP_SUB) begin
                  r_lt <= r_carry_out;
                  r_eq <= ~(|r_result) & ~r_carry_out;
                  r_gt <= ~r_carry_out & (|r_result);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = (r_state != StIdle) | r_done;
   assign done      = r_done;
   assign result    = r_result;
   assign carry_out = r_carry_out;
   assign a_greater = r_gt;
   assign a_equal   = r_eq;
   assign a_less    = r_lt;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
module tb_serial_addsub_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // WIDTH=8 instance
   logic       start8 = 1'b0, op8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0, res8;
   logic       busy8, done8, co8, g8, e8, l8;
   // WIDTH=4 instance
   logic       start4 = 1'b0, op4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0, res4;
   logic       busy4, done4, co4, g4, e4, l4;

   serial_addsub_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .result(res8), .carry_out(co8),
      .a_greater(g8), .a_equal(e8), .a_less(l8)
   );

   serial_addsub_ctrl #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .op(op4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .result(res4), .carry_out(co4),
      .a_greater(g4), .a_equal(e4), .a_less(l4)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       co;
      logic       g;
      logic       e;
      logic       l;
   } vec_t;

   vec_t vecs[9];

   // Starts an operation on the 8-bit DUT and returns in the done cycle (+1).
   task automatic run8(input logic op, input logic [7:0] a, input logic [7:0] b,
                       output int lat);
      @(posedge clk); #1;
      start8 = 1'b1; op8 = op; a8 = a; b8 = b;
      @(posedge clk); #1;
      start8 = 1'b0;
      lat = 0;
      chk("busy_after_accept", {31'd0, busy8}, 32'd1);
      while (!done8 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run4(input logic op, input logic [3:0] a, input logic [3:0] b,
                       output int lat);
      @(posedge clk); #1;
      start4 = 1'b1; op4 = op; a4 = a; b4 = b;
      @(posedge clk); #1;
      start4 = 1'b0;
      lat = 0;
      while (!done4 && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      int lat;
      int seen;
      logic [4:0] sum5;
      logic [3:0] eres;
      logic eco, eg, ee, el;

      vecs[0] = '{1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 8'h37, 8'h37, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy8}, 32'd0);
      chk("rst_done", {31'd0, done8}, 32'd0);
      chk("rst_result", {24'd0, res8}, 32'd0);
      chk("rst_flags", {28'd0, co8, g8, e8, l8}, 32'd0);
      rst = 1'b0;

      // Table-driven vectors
      for (int i = 0; i < 9; i++) begin
         run8(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         chk($sformatf("v%0d_latency", i), lat, 32'd9);
         chk($sformatf("v%0d_busy_in_done", i), {31'd0, busy8}, 32'd1);
         chk($sformatf("v%0d_result", i), {24'd0, res8}, {24'd0, vecs[i].res});
         chk($sformatf("v%0d_carry", i), {31'd0, co8}, {31'd0, vecs[i].co});
         chk($sformatf("v%0d_flags", i), {29'd0, g8, e8, l8},
             {29'd0, vecs[i].g, vecs[i].e, vecs[i].l});
         @(posedge clk); #1;
         chk($sformatf("v%0d_done_pulse", i), {30'd0, done8, busy8}, 32'd0);
      end

      // Start during busy is ignored; result held afterwards
      @(posedge clk); #1;
      start8 = 1'b1; op8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
      @(posedge clk); #1;
      start8 = 1'b0;
      @(posedge clk); #1;
      start8 = 1'b1; op8 = 1'b1; a8 = 8'hFF; b8 = 8'h0F;
      repeat (3) @(posedge clk);
      #1;
      start8 = 1'b0;
      lat = 0;
      while (!done8 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("busy_ign_done_seen", {31'd0, done8}, 32'd1);
      chk("busy_ign_result", {24'd0, res8}, 32'h46);
      repeat (3) @(posedge clk);
      #1;
      chk("busy_ign_held", {24'd0, res8}, 32'h46);
      chk("busy_ign_idle", {31'd0, busy8}, 32'd0);

      // Start in the first cycle after done is accepted
      run8(1'b0, 8'h01, 8'h02, lat);
      @(posedge clk); #1;
      chk("after_done_busy", {31'd0, busy8}, 32'd0);
      start8 = 1'b1; op8 = 1'b1; a8 = 8'h09; b8 = 8'h04;
      @(posedge clk); #1;
      start8 = 1'b0;
      chk("after_done_accept", {31'd0, busy8}, 32'd1);
      lat = 0;
      while (!done8 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("after_done_latency", lat, 32'd9);
      chk("after_done_result", {24'd0, res8}, 32'h05);
      chk("after_done_flags", {29'd0, g8, e8, l8}, 32'b100);

      // Reset while bit 4 is processed aborts with no done pulse
      @(posedge clk); #1;
      start8 = 1'b1; op8 = 1'b0; a8 = 8'hFF; b8 = 8'h00;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", {31'd0, busy8}, 32'd0);
      chk("abort_result", {24'd0, res8}, 32'd0);
      chk("abort_done", {31'd0, done8}, 32'd0);
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (done8) seen++;
      end
      chk("abort_no_done", seen, 32'd0);
      run8(1'b0, 8'hA5, 8'h5B, lat);
      chk("post_abort_latency", lat, 32'd9);
      chk("post_abort_result", {23'd0, co8, res8}, 32'h100);

      // WIDTH=4 exhaustive against reference model
      for (int o = 0; o < 2; o++) begin
         for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
               run4(o[0], x[3:0], y[3:0], lat);
               if (o == 0) begin
                  sum5 = {1'b0, x[3:0]} + {1'b0, y[3:0]};
                  eres = sum5[3:0];
                  eco  = sum5[4];
                  eg = 1'b0; ee = 1'b0; el = 1'b0;
               end else begin
                  eres = x[3:0] - y[3:0];
                  eco  = (x < y);
                  eg = (x > y); ee = (x == y); el = (x < y);
               end
               chk($sformatf("w4_op%0d_%0h_%0h", o, x, y),
                   {22'd0, lat[1:0] == 2'd1 && lat == 5, res4, co4, g4, e4, l4},
                   {22'd0, 1'b1, eres, eco, eg, ee, el});
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
